// File: rtl/pio_input_capture_if.sv
// Slave bus bundle for the input PIO: 2-bit address, chipselect/write_n strobes,
// 32-bit data, zero-wait-state combinational read and a level interrupt.
interface pio_input_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_input_capture.sv
// Input PIO: per-bit 2-flop synchronizer and debouncer, debounced DATA register,
// sticky edge-capture register with write-1-to-clear, and masked level interrupt.
module pio_input_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_port,
  pio_input_capture_if.slave   bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_PATTERN = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic        wr_en;
  logic        wr_mask;
  logic        wr_edgecap;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_mask    = wr_en && (bus.address == 2'd2);
  assign wr_edgecap = wr_en && (bus.address == 2'd3);
  assign unused_wdata = ^bus.writedata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic differ;
      logic commit;
      logic rise;
      logic fall;
      logic clr;

      assign differ = sync2_q[gi] ^ stable_q[gi];
      assign commit = differ && (cnt_q[gi] == CNT_LAST);
      assign rise   = commit &  sync2_q[gi];
      assign fall   = commit & ~sync2_q[gi];

      // Any return to the stable level before commit restarts the count.
      assign cnt_d[gi]    = (!differ || commit) ? '0 : cnt_q[gi] + 1'b1;
      assign stable_d[gi] = commit ? sync2_q[gi] : stable_q[gi];

      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_evt[gi] = rise;
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_evt[gi] = fall;
      end else begin : g_any
        assign edge_evt[gi] = rise | fall;
      end

      // A new edge event beats a simultaneous write-1-to-clear.
      assign clr           = wr_edgecap & bus.writedata[gi];
      assign edgecap_d[gi] = edge_evt[gi] | (edgecap_q[gi] & ~clr);
    end
  endgenerate

  assign irqmask_d = wr_mask ? bus.writedata[WIDTH-1:0] : irqmask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= IDLE_PATTERN;
      sync2_q   <= IDLE_PATTERN;
      stable_q  <= IDLE_PATTERN;
      cnt_q     <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      2'd0:    rdata[WIDTH-1:0] = stable_q;
      2'd2:    rdata[WIDTH-1:0] = irqmask_q;
      2'd3:    rdata[WIDTH-1:0] = edgecap_q;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule
